// File: rtl/brick_pkg.sv
// Shared constants, FSM state encoding and brick-index helper for the brick field.
// The optional combo scoring feature is enabled by defining BRICK_COMBO_EN.
package brick_pkg;

  localparam int DEF_ROWS    = 7;
  localparam int DEF_COLS    = 16;
  localparam int DEF_BRICK_W = 2;
  localparam int DEF_HP_W    = 2;
  localparam int DEF_INIT_HP = 1;
  localparam int DEF_SCORE_W = 10;

  localparam logic [0:0] ST_PLAY  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef enum logic [0:0] {
    PLAY  = ST_PLAY,
    CLEAR = ST_CLEAR
  } state_e;

  // Bricks are numbered row-major, one index per BRICK_W-wide group of columns.
  function automatic int brick_index(input int row, input int col,
                                     input int cols, input int brick_w);
    return row * (cols / brick_w) + col / brick_w;
  endfunction

endpackage

// File: rtl/brick_cell.sv
// One brick: a hit-point counter that reloads on level start and counts down on hits.
module brick_cell
  import brick_pkg::*;
#(
  parameter int HP_W    = DEF_HP_W,
  parameter int INIT_HP = DEF_INIT_HP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_dec,
  output logic [HP_W-1:0] o_hp,
  output logic            o_alive
);

  logic [HP_W-1:0] r_hp;

  // Hit-point counter: reload wins over decrement; a dead brick never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hp <= HP_W'(INIT_HP);
    end else if (i_load) begin
      r_hp <= HP_W'(INIT_HP);
    end else if (i_dec && (r_hp != {HP_W{1'b0}})) begin
      r_hp <= r_hp - HP_W'(1);
    end
  end

  assign o_hp    = r_hp;
  assign o_alive = (r_hp != {HP_W{1'b0}});

endmodule

// File: rtl/brick_field.sv
// Brick field: per-brick hit points, score, remaining count and PLAY/CLEAR level FSM.
// Define BRICK_COMBO_EN to enable the 2-bit combo multiplier cleared by paddle hits.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int HP_W    = DEF_HP_W,
  parameter int INIT_HP = DEF_INIT_HP,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          ball_valid,
  input  logic [3:0]                                    ball_row,
  input  logic [3:0]                                    ball_col,
  input  logic                                          paddle_hit,
  input  logic                                          new_level,
  output logic [ROWS*COLS/BRICK_W-1:0]                  bricks,
  output logic [SCORE_W-1:0]                            score,
  output logic [$clog2(ROWS*COLS/BRICK_W+1)-1:0]        remaining,
  output logic                                          hit,
  output logic [$clog2(ROWS*COLS/BRICK_W)-1:0]          hit_index,
  output logic                                          cleared
);

  localparam int NB    = ROWS * COLS / BRICK_W;
  localparam int IDX_W = $clog2(NB);
  localparam int REM_W = $clog2(NB + 1);
  localparam logic [REM_W-1:0] NB_CNT = REM_W'(NB);

  state_e              r_state;
  logic [SCORE_W-1:0]  r_score;
  logic [REM_W-1:0]    r_remaining;
  logic                r_hit;
  logic [IDX_W-1:0]    r_hit_index;
  logic                r_cleared;

  logic [HP_W-1:0]     w_hp [NB];
  logic [NB-1:0]       w_alive;
  logic                w_in_field;
  logic                w_hit_valid;
  logic                w_kill;
  logic [IDX_W-1:0]    w_idx;
  logic [SCORE_W:0]    w_points;
  logic [SCORE_W:0]    w_sum;

`ifdef BRICK_COMBO_EN
  logic [1:0]          r_combo;
`else
  logic                w_unused_paddle;
  assign w_unused_paddle = paddle_hit;
`endif

  for (genvar g = 0; g < NB; g++) begin : g_cell
    brick_cell #(
      .HP_W    (HP_W),
      .INIT_HP (INIT_HP)
    ) u_cell (
      .clock   (clock),
      .reset   (reset),
      .i_load  (new_level),
      .i_dec   (w_hit_valid && (w_idx == IDX_W'(g))),
      .o_hp    (w_hp[g]),
      .o_alive (w_alive[g])
    );
  end

  // Hit qualification: new_level and the CLEAR state both suppress hits.
  always_comb begin
    w_in_field  = (32'(ball_row) < ROWS) && (32'(ball_col) < COLS);
    w_idx       = IDX_W'(brick_index(int'(ball_row), int'(ball_col), COLS, BRICK_W));
    w_hit_valid = 1'b0;
    w_kill      = 1'b0;
    if ((r_state == PLAY) && ball_valid && w_in_field && !new_level) begin
      w_hit_valid = w_alive[w_idx];
      w_kill      = w_alive[w_idx] && (w_hp[w_idx] == HP_W'(1));
    end else begin
      w_hit_valid = 1'b0;
      w_kill      = 1'b0;
    end
`ifdef BRICK_COMBO_EN
    w_points = (SCORE_W + 1)'(1) << r_combo;
`else
    w_points = (SCORE_W + 1)'(1);
`endif
    w_sum = {1'b0, r_score} + w_points;
  end

  // Level FSM, remaining count and registered hit reporting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= PLAY;
      r_remaining <= NB_CNT;
      r_score     <= {SCORE_W{1'b0}};
      r_hit       <= 1'b0;
      r_hit_index <= {IDX_W{1'b0}};
      r_cleared   <= 1'b0;
    end else begin
      r_hit     <= w_hit_valid;
      r_cleared <= 1'b0;
      if (w_hit_valid) begin
        r_hit_index <= w_idx;
        r_score     <= w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
      end
      if (new_level) begin
        r_state     <= PLAY;
        r_remaining <= NB_CNT;
      end else if (w_kill) begin
        r_remaining <= r_remaining - REM_W'(1);
        if (r_remaining == REM_W'(1)) begin
          r_state   <= CLEAR;
          r_cleared <= 1'b1;
        end
      end
    end
  end

`ifdef BRICK_COMBO_EN
  // Combo multiplier: the current hit scores at the old value before any clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_combo <= 2'd0;
    end else if (paddle_hit || new_level) begin
      r_combo <= 2'd0;
    end else if (w_hit_valid && (r_combo != 2'd3)) begin
      r_combo <= r_combo + 2'd1;
    end
  end
`endif

  assign bricks    = w_alive;
  assign score     = r_score;
  assign remaining = r_remaining;
  assign hit       = r_hit;
  assign hit_index = r_hit_index;
  assign cleared   = r_cleared;

endmodule

// File: tb/tb_brick_field.sv
// Directed self-checking bench for brick_field: default instance plus an INIT_HP=3 instance.
module tb_brick_field;

  localparam logic [55:0] ALL = 56'hFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ball_valid = 1'b0;
  logic [3:0]  ball_row = 4'd0;
  logic [3:0]  ball_col = 4'd0;
  logic        paddle_hit = 1'b0;
  logic        new_level = 1'b0;

  logic [55:0] bricks, d3_bricks;
  logic [9:0]  score, d3_score;
  logic [5:0]  remaining, d3_remaining;
  logic        hit, d3_hit;
  logic [5:0]  hit_index, d3_hit_index;
  logic        cleared, d3_cleared;

  int total = 0;
  int bad = 0;
  logic [55:0] exp_bricks;

  brick_field dut (
    .clock(clock), .reset(reset), .ball_valid(ball_valid), .ball_row(ball_row),
    .ball_col(ball_col), .paddle_hit(paddle_hit), .new_level(new_level),
    .bricks(bricks), .score(score), .remaining(remaining), .hit(hit),
    .hit_index(hit_index), .cleared(cleared)
  );

  brick_field #(.INIT_HP(3)) dut3 (
    .clock(clock), .reset(reset), .ball_valid(ball_valid), .ball_row(ball_row),
    .ball_col(ball_col), .paddle_hit(paddle_hit), .new_level(new_level),
    .bricks(d3_bricks), .score(d3_score), .remaining(d3_remaining), .hit(d3_hit),
    .hit_index(d3_hit_index), .cleared(d3_cleared)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ball_valid = 1'b0;
    paddle_hit = 1'b0;
    new_level  = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic hit_at(input int r, input int c);
    ball_valid = 1'b1;
    ball_row   = 4'(r);
    ball_col   = 4'(c);
    tick();
    ball_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bricks !== ALL) begin bad++; $display("FAIL reset_bricks got=%h exp=%h", bricks, ALL); end
    total++; if (score !== 10'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
    total++; if (remaining !== 6'd56) begin bad++; $display("FAIL reset_remaining got=%0d exp=56", remaining); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
    total++; if (hit_index !== 6'd0) begin bad++; $display("FAIL reset_hit_index got=%0d exp=0", hit_index); end
    total++; if (cleared !== 1'b0) begin bad++; $display("FAIL reset_cleared got=%b exp=0", cleared); end
    total++; if (d3_bricks !== ALL) begin bad++; $display("FAIL reset_hp3_bricks got=%h exp=%h", d3_bricks, ALL); end
  endtask

  task automatic test_single_hit();
    exp_bricks = ALL;
    exp_bricks[18] = 1'b0;
    hit_at(2, 5);
    total++; if (bricks !== exp_bricks) begin bad++; $display("FAIL hit_bricks got=%h exp=%h", bricks, exp_bricks); end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL hit_pulse got=%b exp=1", hit); end
    total++; if (hit_index !== 6'd18) begin bad++; $display("FAIL hit_index got=%0d exp=18", hit_index); end
    total++; if (score !== 10'd1) begin bad++; $display("FAIL hit_score got=%0d exp=1", score); end
    total++; if (remaining !== 6'd55) begin bad++; $display("FAIL hit_remaining got=%0d exp=55", remaining); end
    tick();
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL hit_one_cycle got=%b exp=0", hit); end
    total++; if (hit_index !== 6'd18) begin bad++; $display("FAIL hit_index_hold got=%0d exp=18", hit_index); end
    hit_at(2, 4);
    total++; if (score !== 10'd1) begin bad++; $display("FAIL dead_brick_score got=%0d exp=1", score); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL dead_brick_hit got=%b exp=0", hit); end
  endtask

  task automatic test_out_of_field();
    hit_at(7, 3);
    total++; if (bricks !== exp_bricks) begin bad++; $display("FAIL row7_bricks got=%h exp=%h", bricks, exp_bricks); end
    total++; if (score !== 10'd1) begin bad++; $display("FAIL row7_score got=%0d exp=1", score); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL row7_hit got=%b exp=0", hit); end
    hit_at(15, 15);
    total++; if (bricks !== exp_bricks) begin bad++; $display("FAIL row15_bricks got=%h exp=%h", bricks, exp_bricks); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL row15_hit got=%b exp=0", hit); end
    ball_row = 4'd0;
    ball_col = 4'd0;
    tick();
    total++; if (bricks !== exp_bricks) begin bad++; $display("FAIL novalid_bricks got=%h exp=%h", bricks, exp_bricks); end
  endtask

  task automatic test_back_to_back();
    hit_at(0, 0);
    total++; if (hit_index !== 6'd0 || hit !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0d/%b exp=0/1", hit_index, hit); end
    hit_at(6, 15);
    exp_bricks[0]  = 1'b0;
    exp_bricks[55] = 1'b0;
    total++; if (hit_index !== 6'd55 || hit !== 1'b1) begin bad++; $display("FAIL b2b_second got=%0d/%b exp=55/1", hit_index, hit); end
    total++; if (score !== 10'd3) begin bad++; $display("FAIL b2b_score got=%0d exp=3", score); end
    total++; if (remaining !== 6'd53) begin bad++; $display("FAIL b2b_remaining got=%0d exp=53", remaining); end
    total++; if (bricks !== exp_bricks) begin bad++; $display("FAIL b2b_bricks got=%h exp=%h", bricks, exp_bricks); end
  endtask

  task automatic test_new_level_conflict();
    new_level = 1'b1;
    hit_at(1, 0);
    new_level = 1'b0;
    total++; if (bricks !== ALL) begin bad++; $display("FAIL nl_bricks got=%h exp=%h", bricks, ALL); end
    total++; if (score !== 10'd3) begin bad++; $display("FAIL nl_score got=%0d exp=3", score); end
    total++; if (remaining !== 6'd56) begin bad++; $display("FAIL nl_remaining got=%0d exp=56", remaining); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL nl_hit got=%b exp=0", hit); end
    hit_at(1, 0);
    total++; if (hit !== 1'b1 || hit_index !== 6'd8) begin bad++; $display("FAIL nl_after got=%b/%0d exp=1/8", hit, hit_index); end
    total++; if (score !== 10'd4) begin bad++; $display("FAIL nl_after_score got=%0d exp=4", score); end
  endtask

  task automatic test_combo();
    int pts [5];
    int exp_score;
`ifdef BRICK_COMBO_EN
    pts = '{1, 2, 4, 8, 8};
`else
    pts = '{1, 1, 1, 1, 1};
`endif
    apply_reset();
    exp_score = 0;
    for (int k = 0; k < 5; k++) begin
      hit_at(3, 2 * k);
      exp_score += pts[k];
      total++; if (score !== 10'(exp_score)) begin bad++; $display("FAIL combo_hit%0d got=%0d exp=%0d", k, score, exp_score); end
    end
    paddle_hit = 1'b1;
    tick();
    paddle_hit = 1'b0;
    hit_at(3, 10);
    exp_score += 1;
    total++; if (score !== 10'(exp_score)) begin bad++; $display("FAIL combo_after_paddle got=%0d exp=%0d", score, exp_score); end
    paddle_hit = 1'b1;
    hit_at(3, 12);
    paddle_hit = 1'b0;
`ifdef BRICK_COMBO_EN
    exp_score += 2;
`else
    exp_score += 1;
`endif
    total++; if (score !== 10'(exp_score)) begin bad++; $display("FAIL combo_paddle_same got=%0d exp=%0d", score, exp_score); end
    hit_at(3, 14);
    exp_score += 1;
    total++; if (score !== 10'(exp_score)) begin bad++; $display("FAIL combo_cleared got=%0d exp=%0d", score, exp_score); end
  endtask

  task automatic test_hp3();
    apply_reset();
    hit_at(0, 0);
    total++; if (d3_bricks[0] !== 1'b1 || d3_hit !== 1'b1) begin bad++; $display("FAIL hp3_first got=%b/%b exp=1/1", d3_bricks[0], d3_hit); end
    total++; if (d3_remaining !== 6'd56) begin bad++; $display("FAIL hp3_rem1 got=%0d exp=56", d3_remaining); end
    hit_at(0, 1);
    total++; if (d3_bricks[0] !== 1'b1 || d3_score !== 10'd2) begin bad++; $display("FAIL hp3_second got=%b/%0d exp=1/2", d3_bricks[0], d3_score); end
    total++; if (d3_remaining !== 6'd56) begin bad++; $display("FAIL hp3_rem2 got=%0d exp=56", d3_remaining); end
    hit_at(0, 0);
    total++; if (d3_bricks[0] !== 1'b0) begin bad++; $display("FAIL hp3_third got=%b exp=0", d3_bricks[0]); end
    total++; if (d3_score !== 10'd3) begin bad++; $display("FAIL hp3_score got=%0d exp=3", d3_score); end
    total++; if (d3_remaining !== 6'd55) begin bad++; $display("FAIL hp3_rem3 got=%0d exp=55", d3_remaining); end
  endtask

  task automatic test_clear_all();
    int k;
    int pulses;
    apply_reset();
    k = 0;
    pulses = 0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 16; c += 2) begin
        hit_at(r, c);
        k++;
        if (cleared === 1'b1) pulses++;
        total++; if (cleared !== (k == 56)) begin bad++; $display("FAIL clear_pulse_k%0d got=%b exp=%b", k, cleared, (k == 56)); end
      end
    end
    total++; if (remaining !== 6'd0) begin bad++; $display("FAIL clear_remaining got=%0d exp=0", remaining); end
    total++; if (score !== 10'd56) begin bad++; $display("FAIL clear_score got=%0d exp=56", score); end
    total++; if (bricks !== 56'd0) begin bad++; $display("FAIL clear_bricks got=%h exp=0", bricks); end
    tick();
    total++; if (cleared !== 1'b0) begin bad++; $display("FAIL clear_one_cycle got=%b exp=0", cleared); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL clear_pulse_count got=%0d exp=1", pulses); end
    hit_at(0, 0);
    total++; if (hit !== 1'b0 || score !== 10'd56) begin bad++; $display("FAIL clear_ignore got=%b/%0d exp=0/56", hit, score); end
    new_level = 1'b1;
    tick();
    new_level = 1'b0;
    total++; if (bricks !== ALL) begin bad++; $display("FAIL relevel_bricks got=%h exp=%h", bricks, ALL); end
    total++; if (score !== 10'd56) begin bad++; $display("FAIL relevel_score got=%0d exp=56", score); end
    total++; if (remaining !== 6'd56) begin bad++; $display("FAIL relevel_remaining got=%0d exp=56", remaining); end
    hit_at(0, 0);
    total++; if (hit !== 1'b1 || score !== 10'd57) begin bad++; $display("FAIL relevel_play got=%b/%0d exp=1/57", hit, score); end
  endtask

  task automatic test_reset_mid_hit();
    ball_valid = 1'b1;
    ball_row   = 4'd1;
    ball_col   = 4'd2;
    #2;
    reset = 1'b0;
    tick();
    ball_valid = 1'b0;
    total++; if (score !== 10'd0) begin bad++; $display("FAIL midrst_score got=%0d exp=0", score); end
    total++; if (bricks !== ALL) begin bad++; $display("FAIL midrst_bricks got=%h exp=%h", bricks, ALL); end
    total++; if (hit !== 1'b0 || remaining !== 6'd56) begin bad++; $display("FAIL midrst_hit_rem got=%b/%0d exp=0/56", hit, remaining); end
    reset = 1'b1;
    tick();
    total++; if (bricks !== ALL || score !== 10'd0) begin bad++; $display("FAIL midrst_after got=%h/%0d exp=%h/0", bricks, score, ALL); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_out_of_field();
    test_back_to_back();
    test_new_level_conflict();
    test_combo();
    test_hp3();
    test_clear_all();
    test_reset_mid_hit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
